tlp_recv_ext: RTL and testbench
===============================

Name: tlp_recv_ext

Overview:
Parametrised next-generation TLP receiver for the 64-bit Avalon-ST RX stream from the PCIe hard IP.
- Decodes 3DW and 4DW memory reads and writes plus CplD completions.
- Emits register actions (tlp_xcvr_pkg::Action) to tlp_send through a ready/valid handshake.
- Streams multi-QW completion payloads to the CPU->FPGA pipe with backpressure, correct odd-DW handling, malformed/unsupported TLP draining and an error counter.

Parameters:
CHAN_BITS, 6, number of valid register-channel bits; qwAddr[CHAN_BITS-1:0] selects the channel, zero-extended to ExtChan.
MAX_CMP_QW, 16, largest completion payload accepted, in QWs; sizes the QW counter as $clog2(MAX_CMP_QW)+1 bits.
ENABLE_4DW, 1, when 1, MRd64/MWr64 are decoded; when 0 they are treated as unsupported.

Ports:
pcieClk_in  in  1  125MHz core clock
pcieRst_in  in  1  synchronous, active-high reset
rxData_in  in  64  RX beat
rxValid_in  in  1  RX beat valid
rxReady_out  out  1  RX beat accept
rxSOP_in  in  1  first beat of TLP
rxEOP_in  in  1  last beat of TLP
actData_out  out  Action  register action to tlp_send
actValid_out  out  1  action valid (registered)
actReady_in  in  1  action consumed
c2fData_out  out  64  completion payload QW
c2fValid_out  out  1  payload valid
c2fReady_in  in  1  payload sink ready
c2fLast_out  out  1  final payload QW of this completion
errCount_out  out  16  dropped-TLP count, saturating at 0xFFFF

Behaviour:
- Clocking and reset: one clock, pcieClk_in; pcieRst_in is synchronous, active-high.
- During reset and on the cycle after, all outputs are 0: actValid_out, c2fValid_out, c2fLast_out, errCount_out, rxReady_out. State goes to S_IDLE.
- Reset mid-TLP abandons the TLP. The remaining beats arriving after reset have no SOP and are ignored in S_IDLE.
- A beat is taken only when rxValid_in && rxReady_out. States advance only on a taken beat.
- Action stall: rxReady_out = !(actValid_out && !actReady_in) in every state except S_CMP_DATA.
- In S_CMP_DATA: rxReady_out = c2fReady_in; c2fValid_out = rxValid_in; c2fData_out = rxData_in. This path is combinational, zero latency.
- States: S_IDLE, S_RD1, S_RD4, S_WR1, S_WR4A, S_WR4D, S_CMP1, S_CMP_DATA, S_DRAIN.
- S_IDLE, non-SOP beats are ignored. On an SOP beat, decode fmt/typ/length:
  - MRd 3DW, length 1..2 -> capture reqID and tag -> S_RD1.
  - MRd 4DW (ENABLE_4DW=1), length 1..2 -> same capture -> S_RD4.
  - MWr 3DW, length 1 -> S_WR1.
  - MWr 4DW (ENABLE_4DW=1), length 1 -> S_WR4A.
  - CplD 3DW -> nQW = ceil(dwCount/2), where dwCount=0 means 1024.
    - If nQW <= MAX_CMP_QW: record odd = dwCount[0] -> S_CMP1.
    - Otherwise: error.
  - Anything else: error.
  - Error: errCount++; if rxEOP_in is set on the same beat stay in S_IDLE, else go to S_DRAIN.
- S_RD1: addr = DW2.
- S_RD4: addr = DW3; DW2 (upper 32 bits) must be 0, else error -> S_IDLE.
- Read action: if qwAddr bits above CHAN_BITS are nonzero, error. Otherwise register genRegRead(chan, reqID, tag) -> S_IDLE.
- S_WR1: addr = DW2, data = DW3. Same channel check, then register genRegWrite(chan, data) -> S_IDLE.
- S_WR4A: capture addr -> S_WR4D.
- S_WR4D: data = low DW; issue genRegWrite -> S_IDLE.
- Any error from S_RDx/S_WRx goes to S_DRAIN if rxEOP_in is clear on that beat.
- actValid_out is set 1 cycle after the final header/data beat and held with actData_out stable until actReady_in is high.
- Back-to-back actions: a new action may load on the same edge the old one is consumed.
- S_CMP1 discards QW1 (completions are QW-aligned); load qwLeft = nQW -> S_CMP_DATA.
- S_CMP_DATA, per taken beat, qwLeft--. c2fLast_out = (qwLeft==1) && c2fValid_out.
  - When the last QW is taken with rxEOP_in set -> S_IDLE.
  - If odd, the upper DW of the last QW is don't-care; the sink uses the DW count.
  - rxEOP_in before the last QW: that beat is still forwarded, c2fLast_out is forced 1 on it, errCount++ -> S_IDLE.
  - Last QW taken without rxEOP_in: errCount++ -> S_DRAIN.
- S_DRAIN: accept beats until a taken beat has rxEOP_in set -> S_IDLE. Nothing is emitted.
- An SOP beat seen outside S_IDLE is not decoded.
- errCount_out saturates at 0xFFFF, never wraps.

Test Plan:
- MRd 3DW, reqID 0x0100, tag 0x2A, byte addr 0x18, with actReady_in=1 -> one action genRegRead(3, 0x0100, 0x2A), actValid_out high exactly 1 cycle.
- MWr 4DW, addr hi 0, lo 0x38, data 0xDEADBEEF, with actReady_in held low 5 cycles -> genRegWrite(7, 0xDEADBEEF) held stable; rxReady_out low until consumed; next TLP then accepted.
- CplD dwCount 5 -> 3 QWs on c2f with c2fLast_out on the 3rd; toggling c2fReady_in stalls rxReady_out 1:1 with no loss or duplication.
- CplD dwCount 64 with MAX_CMP_QW=16 -> dropped, 0 c2f beats, errCount_out=1, next MRd still decoded.
- MWr with length 2, then MRd with qwAddr=0x40 (CHAN_BITS=6) -> both dropped, errCount_out=2, no actions.
- pcieRst_in asserted during the 2nd payload QW of a 4-QW CplD -> outputs 0, remaining beats ignored, following MRd decoded normally.

Source files
------------

// File: rtl/tlp_recv_ext.sv
// Avalon-ST 64-bit PCIe RX decoder: MRd/MWr (3DW/4DW) become register actions, CplD payloads stream to c2f.
// Action word: [63:62] kind (01 read, 10 write), [55:48] chan, read: [47:32] reqID [31:24] tag, write: [31:0] data.
module tlp_recv_ext #(
  parameter int CHAN_BITS  = 6,
  parameter int MAX_CMP_QW = 16,
  parameter bit ENABLE_4DW = 1'b1
) (
  input  logic        pcieClk_in,
  input  logic        pcieRst_in,
  input  logic [63:0] rxData_in,
  input  logic        rxValid_in,
  output logic        rxReady_out,
  input  logic        rxSOP_in,
  input  logic        rxEOP_in,
  output logic [63:0] actData_out,
  output logic        actValid_out,
  input  logic        actReady_in,
  output logic [63:0] c2fData_out,
  output logic        c2fValid_out,
  input  logic        c2fReady_in,
  output logic        c2fLast_out,
  output logic [15:0] errCount_out
);
  localparam int QW_W = $clog2(MAX_CMP_QW) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RD1, S_RD4, S_WR1, S_WR4A, S_WR4D, S_CMP1, S_CMP_DATA, S_DRAIN
  } state_t;

  state_t          r_state, w_stateNxt;
  logic            r_live, r_actValid;
  logic [63:0]     r_actData;
  logic [15:0]     r_errCnt;
  logic [15:0]     r_reqId;
  logic [7:0]      r_tag;
  logic [31:0]     r_addr;
  logic [QW_W-1:0] r_nQw, r_qwLeft;

  logic            w_en, w_take, w_err, w_actLd, w_capHdr, w_capCmp, w_capAddr, w_chanErr;
  logic [63:0]     w_actNxt;
  logic [1:0]      w_fmt;
  logic [4:0]      w_typ;
  logic [9:0]      w_len;
  logic [10:0]     w_dwCnt, w_nQw;
  logic [31:0]     w_addr;
  logic [7:0]      w_chan;

  function automatic logic [63:0] genRegRead(input logic [7:0] chan, input logic [15:0] reqId,
                                             input logic [7:0] tag);
    return {2'b01, 6'd0, chan, reqId, tag, 24'd0};
  endfunction

  function automatic logic [63:0] genRegWrite(input logic [7:0] chan, input logic [31:0] data);
    return {2'b10, 6'd0, chan, 16'd0, data};
  endfunction

  // r_live keeps every output quiet for one cycle after reset is released
  assign w_en    = r_live && !pcieRst_in;
  assign w_take  = rxValid_in && rxReady_out;
  assign w_fmt   = rxData_in[30:29];
  assign w_typ   = rxData_in[28:24];
  assign w_len   = rxData_in[9:0];
  assign w_dwCnt = {(w_len == 10'd0), w_len};
  assign w_nQw   = 11'(w_dwCnt[10:1]) + 11'(w_dwCnt[0]);

  assign w_addr    = (r_state == S_RD4 || r_state == S_WR4A) ? rxData_in[63:32] :
                     (r_state == S_WR4D) ? r_addr : rxData_in[31:0];
  assign w_chanErr = (w_addr >> (3 + CHAN_BITS)) != 32'd0;

  always_comb begin
    w_chan = '0;
    w_chan[CHAN_BITS-1:0] = w_addr[3 +: CHAN_BITS];
  end

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) r_state <= S_IDLE;
    else            r_state <= w_stateNxt;
  end

  always_comb begin
    w_stateNxt = r_state;
    w_err      = 1'b0;
    w_actLd    = 1'b0;
    w_actNxt   = '0;
    w_capHdr   = 1'b0;
    w_capCmp   = 1'b0;
    w_capAddr  = 1'b0;
    if (w_take) begin
      case (r_state)
        S_IDLE: if (rxSOP_in) begin
          if (w_fmt == 2'b00 && w_typ == 5'd0 && (w_len == 10'd1 || w_len == 10'd2)) begin
            w_capHdr = 1'b1; w_stateNxt = S_RD1;
          end else if (ENABLE_4DW && w_fmt == 2'b01 && w_typ == 5'd0 &&
                       (w_len == 10'd1 || w_len == 10'd2)) begin
            w_capHdr = 1'b1; w_stateNxt = S_RD4;
          end else if (w_fmt == 2'b10 && w_typ == 5'd0 && w_len == 10'd1) begin
            w_stateNxt = S_WR1;
          end else if (ENABLE_4DW && w_fmt == 2'b11 && w_typ == 5'd0 && w_len == 10'd1) begin
            w_stateNxt = S_WR4A;
          end else if (w_fmt == 2'b10 && w_typ == 5'b01010 && w_nQw <= 11'(MAX_CMP_QW)) begin
            w_capCmp = 1'b1; w_stateNxt = S_CMP1;
          end else begin
            w_err = 1'b1;
          end
        end
        S_RD1, S_RD4: begin
          if (w_chanErr || (r_state == S_RD4 && rxData_in[31:0] != 32'd0)) w_err = 1'b1;
          else begin
            w_actLd = 1'b1; w_actNxt = genRegRead(w_chan, r_reqId, r_tag); w_stateNxt = S_IDLE;
          end
        end
        S_WR1: begin
          if (w_chanErr) w_err = 1'b1;
          else begin
            w_actLd = 1'b1; w_actNxt = genRegWrite(w_chan, rxData_in[63:32]); w_stateNxt = S_IDLE;
          end
        end
        S_WR4A: begin
          w_capAddr = 1'b1; w_stateNxt = S_WR4D;
        end
        S_WR4D: begin
          if (w_chanErr) w_err = 1'b1;
          else begin
            w_actLd = 1'b1; w_actNxt = genRegWrite(w_chan, rxData_in[31:0]); w_stateNxt = S_IDLE;
          end
        end
        // A completion ending on its second header beat carries no payload: malformed
        S_CMP1: begin
          if (rxEOP_in) w_err = 1'b1;
          else          w_stateNxt = S_CMP_DATA;
        end
        S_CMP_DATA: begin
          if (r_qwLeft == QW_W'(1)) begin
            if (rxEOP_in) w_stateNxt = S_IDLE;
            else          w_err = 1'b1;
          end else if (rxEOP_in) begin
            w_err = 1'b1;
          end
        end
        S_DRAIN: if (rxEOP_in) w_stateNxt = S_IDLE;
        default: w_stateNxt = S_IDLE;
      endcase
      if (w_err) w_stateNxt = rxEOP_in ? S_IDLE : S_DRAIN;
    end
  end

  // Payload bypasses all registers; the odd upper DW is left for the sink to ignore
  always_comb begin
    rxReady_out  = w_en && !(r_actValid && !actReady_in);
    c2fValid_out = 1'b0;
    c2fLast_out  = 1'b0;
    if (r_state == S_CMP_DATA) begin
      rxReady_out  = w_en && c2fReady_in;
      c2fValid_out = w_en && rxValid_in;
      c2fLast_out  = c2fValid_out && (r_qwLeft == QW_W'(1) || rxEOP_in);
    end
  end

  assign c2fData_out  = rxData_in;
  assign actData_out  = r_actData;
  assign actValid_out = r_actValid && w_en;
  assign errCount_out = w_en ? r_errCnt : 16'd0;

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      r_live     <= 1'b0;
      r_actValid <= 1'b0;
      r_actData  <= '0;
      r_errCnt   <= '0;
      r_nQw      <= '0;
      r_qwLeft   <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_actLd) begin
        r_actValid <= 1'b1;
        r_actData  <= w_actNxt;
      end else if (actReady_in) begin
        r_actValid <= 1'b0;
      end
      if (w_err && r_errCnt != 16'hFFFF) r_errCnt <= r_errCnt + 16'd1;
      if (w_capCmp) r_nQw <= QW_W'(w_nQw);
      if (w_take && r_state == S_CMP1)           r_qwLeft <= r_nQw;
      else if (w_take && r_state == S_CMP_DATA)  r_qwLeft <= r_qwLeft - 1'b1;
    end
  end

  always_ff @(posedge pcieClk_in) begin
    if (w_capHdr) begin
      r_reqId <= rxData_in[63:48];
      r_tag   <= rxData_in[47:40];
    end
    if (w_capAddr) r_addr <= rxData_in[63:32];
  end
endmodule

// File: tb/tb_tlp_recv_ext.sv
// Directed bench for tlp_recv_ext: register actions, completion streaming, drops and reset recovery.
module tb_tlp_recv_ext;
  logic        clk = 1'b0, rst = 1'b1;
  logic [63:0] rxData = '0;
  logic        rxValid = 1'b0, rxSOP = 1'b0, rxEOP = 1'b0, rxReady;
  logic [63:0] actData, c2fData;
  logic        actValid, c2fValid, c2fLast;
  logic        actReady = 1'b1, c2fReady = 1'b1;
  logic [15:0] errCount;

  int checks = 0, fails = 0, actCyc = 0;
  logic [63:0] actQ[$];
  logic [63:0] c2fQ[$];
  logic        lastQ[$];

  tlp_recv_ext #(.CHAN_BITS(6), .MAX_CMP_QW(16), .ENABLE_4DW(1'b1)) dut (
    .pcieClk_in(clk), .pcieRst_in(rst),
    .rxData_in(rxData), .rxValid_in(rxValid), .rxReady_out(rxReady),
    .rxSOP_in(rxSOP), .rxEOP_in(rxEOP),
    .actData_out(actData), .actValid_out(actValid), .actReady_in(actReady),
    .c2fData_out(c2fData), .c2fValid_out(c2fValid), .c2fReady_in(c2fReady),
    .c2fLast_out(c2fLast), .errCount_out(errCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Samples mid-cycle, after the negedge drives have settled
  initial forever begin
    @(negedge clk); #2;
    if (actValid) begin
      actCyc++;
      if (actReady) actQ.push_back(actData);
    end
    if (c2fValid && c2fReady) begin
      c2fQ.push_back(c2fData);
      lastQ.push_back(c2fLast);
    end
  end

  function automatic logic [31:0] dw0(input logic [1:0] fmt, input logic [4:0] typ, input logic [9:0] len);
    return {1'b0, fmt, typ, 14'd0, len};
  endfunction

  function automatic logic [63:0] expRd(input logic [7:0] ch, input logic [15:0] rid, input logic [7:0] tg);
    return {2'b01, 6'd0, ch, rid, tg, 24'd0};
  endfunction

  function automatic logic [63:0] expWr(input logic [7:0] ch, input logic [31:0] d);
    return {2'b10, 6'd0, ch, 16'd0, d};
  endfunction

  task automatic beat(input logic [63:0] d, input logic sop, input logic eop);
    int n = 0;
    @(negedge clk);
    rxValid = 1'b1; rxData = d; rxSOP = sop; rxEOP = eop;
    #1;
    while (!rxReady && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) chk("beat_timeout", 64'(rxReady), 64'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    rxValid = 1'b0; rxSOP = 1'b0; rxEOP = 1'b0;
  endtask

  task automatic mrd3(input logic [15:0] rid, input logic [7:0] tg, input logic [31:0] addr);
    beat({rid, tg, 8'h0F, dw0(2'b00, 5'd0, 10'd1)}, 1'b1, 1'b0);
    beat({32'd0, addr}, 1'b0, 1'b1);
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c0;
    // Reset state and the quiet cycle after release
    repeat (2) @(negedge clk);
    #2;
    chk("rst_rxReady", 64'(rxReady), 64'd0);
    chk("rst_actValid", 64'(actValid), 64'd0);
    chk("rst_c2fValid", 64'(c2fValid), 64'd0);
    chk("rst_errCount", 64'(errCount), 64'd0);
    @(negedge clk); rst = 1'b0; #2;
    chk("post_rst_rxReady", 64'(rxReady), 64'd0);
    @(negedge clk); #2;
    chk("live_rxReady", 64'(rxReady), 64'd1);

    // MRd 3DW, byte addr 0x18 -> channel 3
    actQ.delete(); c0 = actCyc;
    mrd3(16'h0100, 8'h2A, 32'h18);
    repeat (3) @(negedge clk);
    chk("mrd3_count", 64'(actQ.size()), 64'd1);
    if (actQ.size() > 0) chk("mrd3_action", actQ[0], expRd(8'd3, 16'h0100, 8'h2A));
    chk("mrd3_valid_cycles", 64'(actCyc - c0), 64'd1);

    // MWr 4DW with the action consumer stalled
    actQ.delete();
    @(negedge clk); actReady = 1'b0;
    beat({32'h0300_0000, dw0(2'b11, 5'd0, 10'd1)}, 1'b1, 1'b0);
    beat({32'h38, 32'h0}, 1'b0, 1'b0);
    beat({32'h0, 32'hDEADBEEF}, 1'b0, 1'b1);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("stall_actValid", 64'(actValid), 64'd1);
      chk("stall_actData", actData, expWr(8'd7, 32'hDEADBEEF));
      chk("stall_rxReady", 64'(rxReady), 64'd0);
    end
    @(negedge clk); actReady = 1'b1; #2;
    chk("unstall_rxReady", 64'(rxReady), 64'd1);
    mrd3(16'h0200, 8'h11, 32'h08);
    repeat (3) @(negedge clk);
    chk("mwr4_count", 64'(actQ.size()), 64'd2);
    if (actQ.size() > 1) begin
      chk("mwr4_action", actQ[0], expWr(8'd7, 32'hDEADBEEF));
      chk("after_stall_mrd", actQ[1], expRd(8'd1, 16'h0200, 8'h11));
    end

    // CplD 5 DW -> 3 QWs, sink ready toggling
    c2fQ.delete(); lastQ.delete();
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          @(negedge clk); c2fReady = (k % 3 != 1);
        end
        c2fReady = 1'b1;
      end
    join_none
    beat({32'h1234_0014, dw0(2'b10, 5'b01010, 10'd5)}, 1'b1, 1'b0);
    beat({32'hAAAA_AAAA, 32'h0100_2A00}, 1'b0, 1'b0);
    beat(64'h1111_1111_0000_0001, 1'b0, 1'b0);
    beat(64'h2222_2222_0000_0002, 1'b0, 1'b0);
    beat(64'h3333_3333_0000_0003, 1'b0, 1'b1);
    idle();
    repeat (18) @(negedge clk);
    chk("cpl5_beats", 64'(c2fQ.size()), 64'd3);
    if (c2fQ.size() == 3) begin
      chk("cpl5_q0", c2fQ[0], 64'h1111_1111_0000_0001);
      chk("cpl5_q1", c2fQ[1], 64'h2222_2222_0000_0002);
      chk("cpl5_q2", c2fQ[2], 64'h3333_3333_0000_0003);
      chk("cpl5_last", 64'({lastQ[0], lastQ[1], lastQ[2]}), 64'b001);
    end
    chk("cpl5_errCount", 64'(errCount), 64'd0);

    // CplD 64 DW exceeds MAX_CMP_QW -> dropped and drained
    c2fQ.delete(); actQ.delete();
    beat({32'h1234_0100, dw0(2'b10, 5'b01010, 10'd64)}, 1'b1, 1'b0);
    beat(64'h0, 1'b0, 1'b0);
    beat(64'h5555_5555_5555_5555, 1'b0, 1'b0);
    beat(64'h6666_6666_6666_6666, 1'b0, 1'b1);
    idle();
    mrd3(16'h0300, 8'h05, 32'h28);
    repeat (3) @(negedge clk);
    chk("big_cpl_beats", 64'(c2fQ.size()), 64'd0);
    chk("big_cpl_errCount", 64'(errCount), 64'd1);
    chk("big_cpl_next_count", 64'(actQ.size()), 64'd1);
    if (actQ.size() > 0) chk("big_cpl_next_mrd", actQ[0], expRd(8'd5, 16'h0300, 8'h05));

    // MWr length 2 and out-of-range channel read, counted from a fresh reset
    do_reset();
    chk("rst2_errCount", 64'(errCount), 64'd0);
    actQ.delete();
    beat({32'h0, dw0(2'b10, 5'd0, 10'd2)}, 1'b1, 1'b0);
    beat({32'h1, 32'h8}, 1'b0, 1'b0);
    beat({32'h0, 32'h2}, 1'b0, 1'b1);
    idle();
    mrd3(16'h0400, 8'h33, 32'h200);
    repeat (3) @(negedge clk);
    chk("drop2_errCount", 64'(errCount), 64'd2);
    chk("drop2_actions", 64'(actQ.size()), 64'd0);

    // Reset while the 2nd payload QW of a 4-QW completion is presented
    c2fQ.delete(); actQ.delete();
    beat({32'h1234_0020, dw0(2'b10, 5'b01010, 10'd8)}, 1'b1, 1'b0);
    beat(64'h0, 1'b0, 1'b0);
    beat(64'hA0A0_A0A0_0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    rxData = 64'hA1A1_A1A1_0000_0001; rxValid = 1'b1; rxSOP = 1'b0; rxEOP = 1'b0; rst = 1'b1;
    #2;
    chk("midrst_rxReady", 64'(rxReady), 64'd0);
    chk("midrst_c2fValid", 64'(c2fValid), 64'd0);
    chk("midrst_c2fLast", 64'(c2fLast), 64'd0);
    chk("midrst_errCount", 64'(errCount), 64'd0);
    @(negedge clk); rst = 1'b0; #2;
    chk("midrst_after_rxReady", 64'(rxReady), 64'd0);
    chk("midrst_after_c2fValid", 64'(c2fValid), 64'd0);
    beat(64'hA2A2_A2A2_0000_0002, 1'b0, 1'b0);
    beat(64'hA3A3_A3A3_0000_0003, 1'b0, 1'b1);
    idle();
    mrd3(16'h0500, 8'h44, 32'h10);
    repeat (3) @(negedge clk);
    chk("midrst_c2f_beats", 64'(c2fQ.size()), 64'd1);
    if (c2fQ.size() > 0) chk("midrst_c2f_q0", c2fQ[0], 64'hA0A0_A0A0_0000_0000);
    chk("midrst_errCount_end", 64'(errCount), 64'd0);
    chk("midrst_next_count", 64'(actQ.size()), 64'd1);
    if (actQ.size() > 0) chk("midrst_next_mrd", actQ[0], expRd(8'd2, 16'h0500, 8'h44));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
